// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin arbiter granting one layer requester the memory port
// Each grant runs IDLE -> BUSY -> RELEASE; BUSY ends on memDone or on a cycle-count timeout.
module mem_access_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        reqRW,
   input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        reqDone,
   output logic                      memEnable,
   output logic                      memRW,
   output logic [ADDR_W-1:0]         memAddr,
   input  logic                      memDone,
   output logic                      timeoutErr
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_done;
   logic               r_mem_en;
   logic               r_mem_rw;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_err;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_last_grant;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   w_winner;
   logic               w_found;
   logic               w_start;
   logic               w_timeout;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && req[(int'(r_last_grant) + k) % NUM_REQ]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
         end
      end
   end

   assign w_start   = enable && w_found;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start) w_next = S_BUSY;
         S_BUSY:    if (memDone || w_timeout) w_next = S_RELEASE;
         S_RELEASE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant      <= '0;
         r_done       <= '0;
         r_mem_en     <= 1'b0;
         r_mem_rw     <= 1'b0;
         r_mem_addr   <= '0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_owner      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= '0;
               if (w_start) begin
                  r_grant    <= NUM_REQ'(1) << w_winner;
                  r_mem_en   <= 1'b1;
                  r_mem_rw   <= reqRW[w_winner];
                  r_mem_addr <= reqAddr[int'(w_winner)*ADDR_W +: ADDR_W];
                  r_cnt      <= '0;
                  r_owner    <= w_winner;
               end
            end
            S_BUSY: begin
               // memDone takes priority so a late completion never reports a timeout.
               if (memDone || w_timeout) begin
                  r_grant      <= '0;
                  r_mem_en     <= 1'b0;
                  r_last_grant <= r_owner;
                  if (memDone) r_done <= r_grant;
                  else         r_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_done <= '0;
         endcase
      end
   end

   assign grant      = r_grant;
   assign reqDone    = r_done;
   assign memEnable  = r_mem_en;
   assign memRW      = r_mem_rw;
   assign memAddr    = r_mem_addr;
   assign timeoutErr = r_err;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - randomized and directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 16;
   localparam int TMO  = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] reqRW = '0;
   logic [NREQ*AW-1:0] reqAddr = '0;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] reqDone;
   logic            memEnable;
   logic            memRW;
   logic [AW-1:0]   memAddr;
   logic            memDone = 1'b0;
   logic            timeoutErr;

   mem_access_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req), .reqRW(reqRW),
      .reqAddr(reqAddr), .grant(grant), .reqDone(reqDone), .memEnable(memEnable),
      .memRW(memRW), .memAddr(memAddr), .memDone(memDone), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit run_cmp = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one transaction at a time, tracked as owner + elapsed busy cycles.
   int              m_own;
   int              m_age;
   bit              m_rel;
   int              m_last;
   bit              m_err;
   logic [NREQ-1:0] m_done;
   logic            m_rw;
   logic [AW-1:0]   m_addr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_own = -1; m_age = 0; m_rel = 0; m_last = NREQ - 1;
         m_err = 0; m_done = '0; m_rw = 0; m_addr = '0;
      end else begin
         m_done = '0;
         if (m_rel) begin
            m_rel = 0;
         end else if (m_own >= 0) begin
            m_age++;
            if (memDone) begin
               m_done[m_own] = 1'b1; m_last = m_own; m_own = -1; m_rel = 1;
            end else if (m_age == TMO) begin
               m_err = 1; m_last = m_own; m_own = -1; m_rel = 1;
            end
         end else if (enable && req != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               int c;
               c = (m_last + k) % NREQ;
               if (req[c]) begin
                  m_own = c;
                  break;
               end
            end
            m_age  = 0;
            m_rw   = reqRW[m_own];
            m_addr = reqAddr[m_own*AW +: AW];
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("grant", grant, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
         chk("memEnable", memEnable, m_own >= 0);
         chk("reqDone", reqDone, m_done);
         chk("timeoutErr", timeoutErr, m_err);
         chk("grant_onehot", $countones(grant) <= 1, 1);
         if (m_own >= 0) begin
            chk("memRW", memRW, m_rw);
            chk("memAddr", memAddr, m_addr);
         end
      end
   end

   // memDone responder: 0 = never, 1 = after dly busy cycles, 2 = random
   int dmode = 0;
   int dly = 2;
   int en_cycles = 0;

   task automatic step();
      @(posedge clk);
      #2;
      if (memEnable) en_cycles++;
      else           en_cycles = 0;
      case (dmode)
         1:       memDone = memEnable && (en_cycles == dly);
         2:       memDone = ($urandom_range(0, 3) == 0);
         default: memDone = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      en_cycles = 0;
   endtask

   task automatic wait_grant(input string nm);
      int c;
      c = 0;
      while (grant == 0 && c < 20) begin
         step();
         c++;
      end
      if (grant == 0) chk({nm, "_grant_wait"}, 0, 1);
   endtask

   logic [NREQ-1:0] g_seq [4];
   logic [AW-1:0]   a_seq [4];
   int              dn [NREQ];
   int              gcyc [4];

   initial begin
      int n;
      int hi;
      logic [NREQ-1:0] prev;

      step();
      run_cmp = 1'b1;
      do_reset();
      chk("reset_grant", grant, 0);
      chk("reset_memEnable", memEnable, 0);
      chk("reset_memAddr", memAddr, 0);

      // enable gating and in-flight completion with enable low
      dmode = 1; dly = 2;
      req = 3'b001; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gated_grant", grant, 0);
      end
      enable = 1'b1;
      step();
      chk("enable_grant", grant, 3'b001);
      enable = 1'b0;
      n = 0;
      while (memEnable && n < 10) begin step(); n++; end
      chk("gated_finish", memEnable, 0);
      chk("gated_reqDone", reqDone, 3'b001);
      step(); step();
      chk("gated_no_regrant", grant, 0);

      // round robin 0,1,2,0 with three active requesters
      req = '0; enable = 1'b1;
      do_reset();
      reqRW = 3'b111;
      reqAddr = {16'h0800, 16'h0400, 16'h0010};
      req = 3'b111;
      n = 0; prev = '0;
      for (int i = 0; i < NREQ; i++) dn[i] = 0;
      for (int c = 0; c < 80 && n < 4; c++) begin
         step();
         if (grant != 0 && prev == 0) begin
            g_seq[n] = grant; a_seq[n] = memAddr; n++;
         end
         for (int i = 0; i < NREQ; i++) dn[i] += int'(reqDone[i]);
         prev = grant;
      end
      chk("rr_count", n, 4);
      chk("rr_g0", g_seq[0], 3'b001); chk("rr_a0", a_seq[0], 16'h0010);
      chk("rr_g1", g_seq[1], 3'b010); chk("rr_a1", a_seq[1], 16'h0400);
      chk("rr_g2", g_seq[2], 3'b100); chk("rr_a2", a_seq[2], 16'h0800);
      chk("rr_g3", g_seq[3], 3'b001);
      for (int i = 0; i < NREQ; i++) chk("rr_done_cnt", dn[i], 1);

      // lone requester regranted every 3 cycles
      req = '0;
      do_reset();
      dly = 1;
      reqRW = 3'b000;
      reqAddr = {16'h0000, 16'h1234, 16'h0000};
      req = 3'b010;
      n = 0; prev = '0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         step();
         if (grant != 0 && prev == 0) begin
            gcyc[n] = c; n++;
            chk("single_grant", grant, 3'b010);
            chk("single_rw", memRW, 0);
            chk("single_addr", memAddr, 16'h1234);
         end
         prev = grant;
      end
      chk("single_count", n, 4);
      for (int i = 1; i < 4; i++) chk("single_period", gcyc[i] - gcyc[i-1], 3);

      // owner changes address and drops req while busy
      req = '0;
      do_reset();
      dly = 3;
      reqAddr = {16'h0800, 16'h0000, 16'h0000};
      req = 3'b100;
      wait_grant("hold");
      reqAddr = {16'hFFFF, 16'h0000, 16'h0000};
      req = 3'b000;
      n = 0;
      while (memEnable && n < 10) begin
         chk("hold_addr", memAddr, 16'h0800);
         step(); n++;
      end
      chk("hold_reqDone", reqDone, 3'b100);

      // timeout: memDone never arrives
      do_reset();
      dmode = 0;
      req = 3'b011;
      wait_grant("tmo");
      chk("tmo_first", grant, 3'b001);
      hi = 1;
      while (hi < 20) begin
         step();
         if (memEnable) hi++;
         else break;
      end
      chk("tmo_len", hi, TMO);
      chk("tmo_err", timeoutErr, 1);
      chk("tmo_no_done", reqDone, 0);
      wait_grant("tmo_next");
      chk("tmo_next", grant, 3'b010);
      chk("tmo_sticky", timeoutErr, 1);

      // asynchronous reset in the middle of a transaction
      req = '0;
      do_reset();
      req = 3'b001;
      wait_grant("arst");
      step();
      reset = 1'b1;
      #1;
      chk("arst_memEnable", memEnable, 0);
      chk("arst_grant", grant, 0);
      chk("arst_reqDone", reqDone, 0);
      chk("arst_memAddr", memAddr, 0);
      req = 3'b110;
      step();
      reset = 1'b0;
      en_cycles = 0;
      wait_grant("arst_after");
      chk("arst_first", grant, 3'b010);

      // randomized traffic
      dmode = 2;
      for (int c = 0; c < 3000; c++) begin
         step();
         req     = NREQ'($urandom);
         reqRW   = NREQ'($urandom);
         reqAddr = {16'($urandom), 16'($urandom), 16'($urandom)};
         enable  = ($urandom_range(0, 7) != 0);
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      end
      reset = 1'b0;
      step();
      step();
      run_cmp = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of layer requesters (0=conv, 1=pool, 2=fc).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max cycles to wait for memDone.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new grants; 0 blocks new grants only.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester access request, level.
REQ-008 SHALL have port reqRW  input  NUM_REQ  per-requester direction, 1=read, 0=write.
REQ-009 SHALL have port reqAddr  input  NUM_REQ*ADDR_W  packed addresses; requester i in bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot owner of the memory port.
REQ-011 SHALL have port reqDone  output  NUM_REQ  one-cycle completion pulse to owner.
REQ-012 SHALL have port memEnable  output  1  transaction active toward memory unit.
REQ-013 SHALL have port memRW  output  1  latched direction of active transaction.
REQ-014 SHALL have port memAddr  output  ADDR_W  latched address of active transaction.
REQ-015 SHALL have port memDone  input  1  memory unit completion, sampled only in BUSY.
REQ-016 SHALL have port timeoutErr  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement states IDLE, BUSY, RELEASE.
REQ-018 IDLE: if enable=1 and any req bit set, SHALL pick winner round-robin starting at (lastGrant+1) mod NUM_REQ, and at that edge go to BUSY.
REQ-019 On entering BUSY SHALL register grant=onehot(winner), memEnable=1, memRW=reqRW[winner], memAddr=reqAddr[winner]; latency req-sampled to memEnable = 1 edge.
REQ-020 memRW, memAddr SHALL hold constant throughout BUSY regardless of requester input changes.
REQ-021 Owner dropping req during BUSY SHALL NOT abort; transaction runs to memDone or timeout.
REQ-022 BUSY: on edge with memDone=1, SHALL go to RELEASE, clear memEnable and grant, pulse reqDone[winner]=1 for exactly one cycle, set lastGrant=winner.
REQ-023 BUSY cycle counter SHALL clear on entry, increment each BUSY cycle; on reaching TIMEOUT without memDone SHALL set timeoutErr=1 and take the REQ-022 exit except reqDone stays 0.
REQ-024 memDone and timeout on same edge: memDone wins, timeoutErr unchanged.
REQ-025 RELEASE SHALL last exactly one cycle, then IDLE unconditionally (gap lets owner drop req).
REQ-026 memDone in IDLE or RELEASE SHALL be ignored.
REQ-027 enable=0 SHALL block only IDLE->BUSY; in-flight transaction completes normally.
REQ-028 Single active requester SHALL be regranted every 3 cycles (BUSY min 1, RELEASE 1, IDLE 1).
REQ-029 grant SHALL be all-zero or one-hot at all times; reqDone at most one bit set.
REQ-030 timeoutErr SHALL clear only on reset.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, grant=0, reqDone=0, memEnable=0, memRW=0, memAddr=0, timeoutErr=0, counter=0, lastGrant=NUM_REQ-1 (requester 0 highest first).
REQ-032 reset mid-BUSY SHALL drop memEnable asynchronously with no reqDone pulse; first grant after release follows REQ-031 priority.

Verification
REQ-033 req=3'b111, all rw=1, addr 0x0010/0x0400/0x0800, memDone 2 cycles after each memEnable -> grants in order 0,1,2,0; memAddr matches; one reqDone pulse each.
REQ-034 Only req[1]=1 held, rw=0, addr 0x1234, memDone 1 cycle after grant -> grant=3'b010 every 3 cycles, memRW=0, memAddr=0x1234.
REQ-035 Owner 2 changes reqAddr 0x0800->0xFFFF and drops req in BUSY -> memAddr stays 0x0800, reqDone[2] still pulses on memDone.
REQ-036 TIMEOUT=8, memDone never asserted -> memEnable high 8 cycles, timeoutErr=1, no reqDone, next requester granted after RELEASE.
REQ-037 enable=0 with req=3'b001 -> no grant; enable=1 -> grant=3'b001 at next edge; enable=0 mid-BUSY -> transaction completes.
REQ-038 reset pulse mid-BUSY -> all outputs 0 at once; after release with req=3'b110 -> grant=3'b010 first.
